// File: rtl/diag_cmd_responder_pkg.sv
// -----------------------------------------------------------------------------
// diag_pkg
// Shared constants, parser state encoding and the frame checksum helper for the
// diagnostics command responder.
//   Request frame : SYNC_REQ, CMD, ARG, CHK   with CHK  = SYNC_REQ ^ CMD  ^ ARG
//   Response frame: SYNC_RSP, RCMD, RDATA, RCHK with RCHK = SYNC_RSP ^ RCMD ^ RDATA
// -----------------------------------------------------------------------------
package diag_pkg;

  localparam logic [7:0] SYNC_REQ      = 8'hA5;
  localparam logic [7:0] SYNC_RSP      = 8'h5A;
  localparam logic [7:0] CMD_PING      = 8'h01;
  localparam logic [7:0] CMD_READ_SW   = 8'h02;
  localparam logic [7:0] CMD_WRITE_LED = 8'h03;
  localparam logic [7:0] RSP_NAK       = 8'hEE;

  localparam int RSP_BYTES = 4;

  typedef enum logic [1:0] {
    P_SYNC,
    P_CMD,
    P_ARG,
    P_CHK
  } parser_state_t;

  // XOR checksum over the three leading bytes of a frame.
  function automatic logic [7:0] xor_chk(input logic [7:0] sync_byte,
                                         input logic [7:0] cmd_byte,
                                         input logic [7:0] arg_byte);
    return sync_byte ^ cmd_byte ^ arg_byte;
  endfunction

endpackage

// File: rtl/diag_rsp_serializer.sv
// -----------------------------------------------------------------------------
// diag_rsp_serializer
// Loads a response (RCMD, RDATA), builds the 4-byte frame SYNC_RSP, RCMD,
// RDATA, RCHK and streams it over a valid/ready byte interface.
// Ports:
//   sample_clock  system clock
//   reset         asynchronous active-low reset
//   load          capture rcmd/rdata and start a new frame (only when can_load)
//   rcmd, rdata   response payload
//   can_load      idle, or the final byte is being handed off this cycle
//   tx_data       current frame byte
//   tx_valid      tx_data valid
//   tx_ready      downstream accepts when tx_valid && tx_ready
//   busy          a frame is being transmitted
// -----------------------------------------------------------------------------
module diag_rsp_serializer
  import diag_pkg::*;
(
  input  logic       sample_clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] rcmd,
  input  logic [7:0] rdata,
  output logic       can_load,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  logic       active_reg, active_next;
  logic [1:0] idx_reg, idx_next;
  logic [7:0] frame_reg [RSP_BYTES];
  logic [7:0] load_bytes [RSP_BYTES];
  logic       handshake;
  logic       last_handshake;

  assign handshake      = active_reg & tx_ready;
  assign last_handshake = handshake & (idx_reg == 2'd3);
  // Accepting a load on the final handshake lets responses run back to back.
  assign can_load       = ~active_reg | last_handshake;

  assign load_bytes[0] = SYNC_RSP;
  assign load_bytes[1] = rcmd;
  assign load_bytes[2] = rdata;
  assign load_bytes[3] = xor_chk(SYNC_RSP, rcmd, rdata);

  always_comb begin
    active_next = active_reg;
    idx_next    = idx_reg;
    if (load) begin
      active_next = 1'b1;
      idx_next    = 2'd0;
    end else if (handshake) begin
      if (idx_reg == 2'd3) begin
        active_next = 1'b0;
        idx_next    = 2'd0;
      end else begin
        idx_next = idx_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      active_reg <= 1'b0;
      idx_reg    <= 2'd0;
    end else begin
      active_reg <= active_next;
      idx_reg    <= idx_next;
    end
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RSP_BYTES; i++) begin
        frame_reg[i] <= 8'h00;
      end
    end else if (load) begin
      for (int i = 0; i < RSP_BYTES; i++) begin
        frame_reg[i] <= load_bytes[i];
      end
    end
  end

  // Output is a pure function of registers, so it holds steady under backpressure.
  assign tx_data  = frame_reg[idx_reg];
  assign tx_valid = active_reg;
  assign busy     = active_reg;

endmodule

// File: rtl/diag_cmd_responder.sv
// -----------------------------------------------------------------------------
// diag_cmd_responder
// Parses 4-byte request frames from the UART receiver, executes PING, READ_SW
// and WRITE_LED, and returns a 4-byte response through the UART transmitter.
// Ports:
//   sample_clock  system clock
//   reset         asynchronous active-low reset
//   rx_data       received byte, qualified by rx_valid (one-cycle strobe)
//   tx_data       response byte, qualified by tx_valid; accepted on tx_ready
//   sw_in         switch state, sampled when a READ_SW frame completes
//   led_out       register written by WRITE_LED
//   err_count     saturating count of protocol errors (bad CHK, unknown CMD,
//                 inter-byte timeout, frame dropped while a response is busy)
//   busy          response in progress
// -----------------------------------------------------------------------------
module diag_cmd_responder
  import diag_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic       sample_clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // CLOCK_FREQ only documents the intended clock; reject nonsense values early.
  if (CLOCK_FREQ <= 0 || TIMEOUT_CYCLES <= 0) begin : g_bad_params
    $error("diag_cmd_responder: CLOCK_FREQ and TIMEOUT_CYCLES must be positive");
  end

  parser_state_t state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    cmd_reg, arg_reg;
  logic [7:0]    led_reg, err_reg;

  logic          frame_done;
  logic          timeout;
  logic          chk_ok;
  logic          cmd_ok;
  logic          write_led;
  logic [7:0]    rsp_cmd;
  logic [7:0]    rsp_data;
  logic          ser_can_load;
  logic          accept;
  logic          err_inc;

  // ---------------------------------------------------------------------------
  // Parser FSM and inter-byte timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state_reg <= P_SYNC;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    frame_done = 1'b0;
    timeout    = 1'b0;
    if (rx_valid) begin
      // A byte always wins over a timeout expiring in the same cycle.
      timer_next = '0;
      case (state_reg)
        P_SYNC: if (rx_data == SYNC_REQ) state_next = P_CMD;
        P_CMD:  state_next = P_ARG;
        P_ARG:  state_next = P_CHK;
        P_CHK: begin
          state_next = P_SYNC;
          frame_done = 1'b1;
        end
        default: state_next = P_SYNC;
      endcase
    end else if (state_reg != P_SYNC) begin
      if (timer_reg == TW'(TIMEOUT_CYCLES)) begin
        timeout    = 1'b1;
        state_next = P_SYNC;
        timer_next = '0;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      cmd_reg <= 8'h00;
      arg_reg <= 8'h00;
    end else if (rx_valid) begin
      if (state_reg == P_CMD) cmd_reg <= rx_data;
      if (state_reg == P_ARG) arg_reg <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decode (valid only while frame_done; rx_data holds CHK then)
  // ---------------------------------------------------------------------------
  assign chk_ok = (xor_chk(SYNC_REQ, cmd_reg, arg_reg) == rx_data);

  always_comb begin
    rsp_cmd   = RSP_NAK;
    rsp_data  = cmd_reg;
    cmd_ok    = 1'b0;
    write_led = 1'b0;
    if (chk_ok) begin
      case (cmd_reg)
        CMD_PING: begin
          rsp_cmd  = CMD_PING;
          rsp_data = arg_reg;
          cmd_ok   = 1'b1;
        end
        CMD_READ_SW: begin
          rsp_cmd  = CMD_READ_SW;
          rsp_data = sw_in;
          cmd_ok   = 1'b1;
        end
        CMD_WRITE_LED: begin
          rsp_cmd   = CMD_WRITE_LED;
          rsp_data  = arg_reg;
          cmd_ok    = 1'b1;
          write_led = 1'b1;
        end
        default: begin
          rsp_cmd  = RSP_NAK;
          rsp_data = cmd_reg;
        end
      endcase
    end
  end

  // A completed frame is only acted on if the serializer can take its response;
  // otherwise it is dropped entirely (no LED write, no response).
  assign accept = frame_done & ser_can_load;

  // Timeout needs !rx_valid and frame errors need rx_valid, so at most one
  // source fires in any cycle.
  assign err_inc = timeout | (frame_done & (~ser_can_load | ~cmd_ok));

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      led_reg <= 8'h00;
      err_reg <= 8'h00;
    end else begin
      if (accept && write_led) led_reg <= arg_reg;
      if (err_inc && err_reg != 8'hFF) err_reg <= err_reg + 8'd1;
    end
  end

  assign led_out   = led_reg;
  assign err_count = err_reg;

  // ---------------------------------------------------------------------------
  // Response serializer
  // ---------------------------------------------------------------------------
  diag_rsp_serializer u_serializer (
    .sample_clock (sample_clock),
    .reset        (reset),
    .load         (accept),
    .rcmd         (rsp_cmd),
    .rdata        (rsp_data),
    .can_load     (ser_can_load),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy)
  );

endmodule

// File: tb/tb_diag_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_diag_cmd_responder
// Directed self-checking bench for diag_cmd_responder. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_diag_cmd_responder;

  localparam int T = 40;

  logic       sample_clock = 1'b0;
  logic       reset        = 1'b0;
  logic [7:0] rx_data      = 8'h00;
  logic       rx_valid     = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready     = 1'b1;
  logic [7:0] sw_in        = 8'h00;
  logic [7:0] led_out;
  logic [7:0] err_count;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 sample_clock = ~sample_clock;

  diag_cmd_responder #(
    .CLOCK_FREQ     (50_000_000),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .sample_clock (sample_clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sw_in        (sw_in),
    .led_out      (led_out),
    .err_count    (err_count),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sample_clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    $display("[TB] rx frame %02h %02h %02h %02h", b0, b1, b2, b3);
  endtask

  // Expects the response to be presented now and on the next 3 cycles
  // (tx_ready held high), i.e. no gaps.
  task automatic expect_rsp(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [4];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), {7'b0, tx_valid}, 8'h01);
      check($sformatf("%s_byte%0d", tag, i), tx_data, exp_b[i]);
      cyc(1);
    end
    $display("[TB] tx frame %s expected %02h %02h %02h %02h", tag, e0, e1, e2, e3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_led", led_out, 8'h00);
    check("rst_err", err_count, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    reset = 1'b1;
    cyc(2);

    // Leading junk ignored, then PING with exact 1-cycle latency
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_err", err_count, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h3C);
    check("ping_pre_valid", {7'b0, tx_valid}, 8'h00);
    send_byte(8'h98);
    check("ping_busy", {7'b0, busy}, 8'h01);
    expect_rsp("ping", 8'h5A, 8'h01, 8'h3C, 8'h67);
    check("ping_idle", {7'b0, tx_valid}, 8'h00);
    check("ping_err", err_count, 8'h00);

    // WRITE_LED then READ_SW
    send_frame(8'hA5, 8'h03, 8'h81, 8'h27);
    check("wled_led", led_out, 8'h81);
    expect_rsp("wled", 8'h5A, 8'h03, 8'h81, 8'hD8);
    sw_in = 8'h96;
    send_frame(8'hA5, 8'h02, 8'h00, 8'hA7);
    sw_in = 8'h11;
    expect_rsp("rsw", 8'h5A, 8'h02, 8'h96, 8'hCE);
    check("rsw_err", err_count, 8'h00);

    // Bad checksum and unknown command
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h00);
    expect_rsp("badchk", 8'h5A, 8'hEE, 8'h01, 8'hB5);
    check("badchk_err", err_count, 8'h01);
    check("badchk_led", led_out, 8'h81);
    send_frame(8'hA5, 8'h7F, 8'h00, 8'hDA);
    expect_rsp("badcmd", 8'h5A, 8'hEE, 8'h7F, 8'hCB);
    check("badcmd_err", err_count, 8'h02);
    check("badcmd_led", led_out, 8'h81);

    // Slow but in-time bytes: no timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    cyc(T - 2);
    send_byte(8'h3C);
    cyc(T - 2);
    send_byte(8'h98);
    expect_rsp("slow", 8'h5A, 8'h01, 8'h3C, 8'h67);
    check("slow_err", err_count, 8'h02);

    // Timeout mid-frame, then a normal PING
    send_byte(8'hA5);
    send_byte(8'h01);
    cyc(T + 5);
    check("tmo_err", err_count, 8'h03);
    check("tmo_valid", {7'b0, tx_valid}, 8'h00);
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h98);
    expect_rsp("tmo_ping", 8'h5A, 8'h01, 8'h3C, 8'h67);
    check("tmo_ping_err", err_count, 8'h03);

    // Backpressure, then overrun drop
    tx_ready = 1'b0;
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h98);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_valid%0d", i), {7'b0, tx_valid}, 8'h01);
      check($sformatf("bp_data%0d", i), tx_data, 8'h5A);
      cyc(1);
    end
    send_frame(8'hA5, 8'h03, 8'h55, 8'hF3);
    check("ovr_err", err_count, 8'h04);
    check("ovr_led", led_out, 8'h81);
    check("ovr_data", tx_data, 8'h5A);
    tx_ready = 1'b1;
    expect_rsp("bp", 8'h5A, 8'h01, 8'h3C, 8'h67);
    check("bp_idle", {7'b0, tx_valid}, 8'h00);

    // Frame completing on the 4th handshake -> back-to-back response
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h98);
    fork
      send_frame(8'hA5, 8'h01, 8'h77, 8'hD3);
      expect_rsp("b2b_first", 8'h5A, 8'h01, 8'h3C, 8'h67);
    join
    expect_rsp("b2b_second", 8'h5A, 8'h01, 8'h77, 8'h2C);
    check("b2b_idle", {7'b0, tx_valid}, 8'h00);
    check("b2b_err", err_count, 8'h04);

    // Asynchronous reset mid-response
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h98);
    cyc(2);
    check("mid_byte2", tx_data, 8'h3C);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {7'b0, tx_valid}, 8'h00);
    check("arst_busy", {7'b0, busy}, 8'h00);
    check("arst_led", led_out, 8'h00);
    check("arst_err", err_count, 8'h00);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h98);
    expect_rsp("post_rst", 8'h5A, 8'h01, 8'h3C, 8'h67);
    check("post_rst_err", err_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
